// File: rtl/pixel_row_memory.sv
// Pixel-array side of the shared pixel bus: per-row exposure integration, ramp-compare latch, one-hot row readout.
// Optional SATURATION_FLAG_EN: rows untripped at the end of a conversion read back all-ones with sat_out set.
module pixel_row_memory #(
  parameter int N_ROWS  = 4,
  parameter int DATA_W  = 8,
  parameter int LIGHT_W = 4,
  parameter int ACC_W   = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       erase,
  input  logic                       expose,
  input  logic                       convert,
  input  logic [N_ROWS-1:0]          read,
  input  logic [DATA_W-1:0]          ramp_code,
  input  logic [N_ROWS*LIGHT_W-1:0]  light,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_oe,
  output logic                       proto_err,
  output logic [N_ROWS-1:0]          busy_row
`ifdef SATURATION_FLAG_EN
  ,output logic                      sat_out
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ
  } state_t;

  state_t              state_q, state_d, phase;
  logic [ACC_W-1:0]    acc_q  [N_ROWS];
  logic [ACC_W-1:0]    acc_d  [N_ROWS];
  logic [DATA_W-1:0]   code_q [N_ROWS];
  logic [DATA_W-1:0]   code_d [N_ROWS];
  logic [N_ROWS-1:0]   tripped_q, tripped_d;
  logic [N_ROWS-1:0]   busy_q, busy_d;
  logic                perr_q, perr_d;
`ifdef SATURATION_FLAG_EN
  logic [N_ROWS-1:0]   sat_q, sat_d;
`endif

  logic                read_any, read_multi, legal, entering;
  logic [2:0]          n_phase;
  logic [ACC_W:0]      sum;
  logic                trip_base, busy_base;

  // Phase decode and legality: one phase per cycle, at most one read strobe.
  always_comb begin
    read_any   = |read;
    read_multi = |(read & (read - {{(N_ROWS-1){1'b0}}, 1'b1}));
    n_phase    = 3'(erase) + 3'(expose) + 3'(convert) + 3'(read_any);
    legal      = (n_phase <= 3'd1) && !read_multi;
    phase      = ST_IDLE;
    if (erase)         phase = ST_ERASE;
    else if (expose)   phase = ST_EXPOSE;
    else if (convert)  phase = ST_CONVERT;
    else if (read_any) phase = ST_READ;
  end

  always_comb begin
    state_d   = state_q;
    tripped_d = tripped_q;
    busy_d    = busy_q;
    perr_d    = perr_q;
    entering  = 1'b0;
    sum       = '0;
    trip_base = 1'b0;
    busy_base = 1'b0;
    for (int i = 0; i < N_ROWS; i++) begin
      acc_d[i]  = acc_q[i];
      code_d[i] = code_q[i];
    end
`ifdef SATURATION_FLAG_EN
    sat_d = sat_q;
`endif

    if (!legal) begin
      perr_d = 1'b1;
    end else begin
      state_d = phase;

      if (convert) begin
        entering = (state_q != ST_CONVERT);
        for (int i = 0; i < N_ROWS; i++) begin
          trip_base    = entering ? 1'b0 : tripped_q[i];
          busy_base    = entering ? 1'b1 : busy_q[i];
          tripped_d[i] = trip_base;
          busy_d[i]    = busy_base;
          if (!trip_base && (ramp_code >= acc_q[i][ACC_W-1 -: DATA_W])) begin
            code_d[i]    = ramp_code;
            tripped_d[i] = 1'b1;
            busy_d[i]    = 1'b0;
`ifdef SATURATION_FLAG_EN
            sat_d[i]     = 1'b0;
`endif
          end
        end
      end else if (state_q == ST_CONVERT) begin
        busy_d = '0;
`ifdef SATURATION_FLAG_EN
        for (int i = 0; i < N_ROWS; i++) begin
          if (!tripped_q[i]) begin
            code_d[i] = '1;
            sat_d[i]  = 1'b1;
          end
        end
`endif
      end

      // Erase is evaluated after the convert-exit handling so it always wins.
      if (erase) begin
        tripped_d = '0;
        for (int i = 0; i < N_ROWS; i++) begin
          acc_d[i]  = '0;
          code_d[i] = '0;
        end
`ifdef SATURATION_FLAG_EN
        sat_d = '0;
`endif
      end

      if (expose) begin
        for (int i = 0; i < N_ROWS; i++) begin
          sum = {1'b0, acc_q[i]} +
                {{(ACC_W+1-LIGHT_W){1'b0}}, light[i*LIGHT_W +: LIGHT_W]};
          acc_d[i] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tripped_q <= '0;
      busy_q    <= '0;
      perr_q    <= 1'b0;
      for (int i = 0; i < N_ROWS; i++) begin
        acc_q[i]  <= '0;
        code_q[i] <= '0;
      end
`ifdef SATURATION_FLAG_EN
      sat_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tripped_q <= tripped_d;
      busy_q    <= busy_d;
      perr_q    <= perr_d;
      for (int i = 0; i < N_ROWS; i++) begin
        acc_q[i]  <= acc_d[i];
        code_q[i] <= code_d[i];
      end
`ifdef SATURATION_FLAG_EN
      sat_q     <= sat_d;
`endif
    end
  end

  // Bus drive is combinational so the parent samples the code on the same edge.
  always_comb begin
    data_out = '0;
    data_oe  = 1'b0;
`ifdef SATURATION_FLAG_EN
    sat_out  = 1'b0;
`endif
    if (legal && read_any) begin
      data_oe = 1'b1;
      for (int i = 0; i < N_ROWS; i++) begin
        if (read[i]) begin
          data_out = code_q[i];
`ifdef SATURATION_FLAG_EN
          sat_out  = sat_q[i];
`endif
        end
      end
    end
  end

  assign proto_err = perr_q;
  assign busy_row  = busy_q;

endmodule

// File: tb/tb_pixel_row_memory.sv
// Bench for pixel_row_memory: directed scenarios plus random cycles, scored against a queue-fed reference model.
module tb_pixel_row_memory;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int AW = 12;
  localparam int ACC_MAX = (1 << AW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           erase = 1'b0, expose = 1'b0, convert = 1'b0;
  logic [NR-1:0]  read = '0;
  logic [DW-1:0]  ramp_code = '0;
  logic [NR*LW-1:0] light = '0;
  logic [DW-1:0]  data_out;
  logic           data_oe, proto_err;
  logic [NR-1:0]  busy_row;
`ifdef SATURATION_FLAG_EN
  logic           sat_out;
`endif

  pixel_row_memory #(.N_ROWS(NR), .DATA_W(DW), .LIGHT_W(LW), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
    .read(read), .ramp_code(ramp_code), .light(light), .data_out(data_out),
    .data_oe(data_oe), .proto_err(proto_err), .busy_row(busy_row)
`ifdef SATURATION_FLAG_EN
    , .sat_out(sat_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int oe;
    int dat;
    int perr;
    int busy;
    int sat;
    int id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_id = 0;

  // Reference model: behavioural per-row state.
  int   m_acc [NR];
  int   m_code[NR];
  bit   m_trip[NR];
  bit   m_busy[NR];
  bit   m_sat [NR];
  bit   m_perr;
  bit   m_in_conv;
  int   m_light[NR];

  task automatic chk(input string nm, input int got, input int exp, input int id);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, id, got, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_acc[i] = 0; m_code[i] = 0; m_trip[i] = 0; m_busy[i] = 0; m_sat[i] = 0;
    end
    m_perr = 0;
    m_in_conv = 0;
  endfunction

  function automatic int busy_vec();
    int v = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic drive_light();
    for (int i = 0; i < NR; i++) light[i*LW +: LW] = m_light[i][LW-1:0];
  endtask

  // One bus cycle: drive, record expected outputs for this cycle, then advance the model past the edge.
  task automatic cyc(input bit e, input bit x, input bit c, input int r, input int ramp);
    exp_t ex;
    int nph, nbits, idx;
    bit legal;
    @(posedge clk); #1;
    reset = 1'b1;
    erase = e; expose = x; convert = c;
    read = r[NR-1:0]; ramp_code = ramp[DW-1:0];
    drive_light();
    nbits = $countones(r[NR-1:0]);
    nph = int'(e) + int'(x) + int'(c) + ((nbits > 0) ? 1 : 0);
    legal = (nph <= 1) && (nbits <= 1);
    idx = 0;
    for (int i = 0; i < NR; i++) if (r[i]) idx = i;
    ex.id   = cyc_id++;
    ex.oe   = (legal && nbits == 1) ? 1 : 0;
    ex.dat  = ex.oe ? m_code[idx] : 0;
    ex.sat  = ex.oe ? int'(m_sat[idx]) : 0;
    ex.perr = int'(m_perr);
    ex.busy = busy_vec();
    q.push_back(ex);

    if (!legal) begin
      m_perr = 1;
    end else begin
      if (c) begin
        if (!m_in_conv) begin
          for (int i = 0; i < NR; i++) m_trip[i] = 0;
          m_in_conv = 1;
        end
        for (int i = 0; i < NR; i++) begin
          if (!m_trip[i] && ramp >= m_acc[i] / (1 << (AW - DW))) begin
            m_code[i] = ramp; m_trip[i] = 1; m_sat[i] = 0;
          end
          m_busy[i] = !m_trip[i];
        end
      end else begin
        if (m_in_conv) begin
          for (int i = 0; i < NR; i++) begin
`ifdef SATURATION_FLAG_EN
            if (!m_trip[i]) begin m_code[i] = (1 << DW) - 1; m_sat[i] = 1; end
`endif
            m_busy[i] = 0;
          end
        end
        m_in_conv = 0;
      end
      if (e) for (int i = 0; i < NR; i++) begin
        m_acc[i] = 0; m_code[i] = 0; m_trip[i] = 0; m_sat[i] = 0;
      end
      if (x) for (int i = 0; i < NR; i++) begin
        m_acc[i] = m_acc[i] + m_light[i];
        if (m_acc[i] > ACC_MAX) m_acc[i] = ACC_MAX;
      end
    end
  endtask

  // Reset cycle; convert may be held high to exercise reset mid-conversion.
  task automatic rst_cyc(input bit c);
    exp_t ex;
    @(posedge clk); #1;
    reset = 1'b0;
    erase = 0; expose = 0; convert = c; read = '0; ramp_code = 8'd7;
    model_reset();
    ex.id = cyc_id++; ex.oe = 0; ex.dat = 0; ex.sat = 0; ex.perr = 0; ex.busy = 0;
    q.push_back(ex);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    idle(1);
    for (int k = 0; k < NR; k++) cyc(0, 0, 0, 1 << k, 0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("data_oe",   int'(data_oe),   mon_e.oe,   mon_e.id);
      chk("data_out",  int'(data_out),  mon_e.dat,  mon_e.id);
      chk("proto_err", int'(proto_err), mon_e.perr, mon_e.id);
      chk("busy_row",  int'(busy_row),  mon_e.busy, mon_e.id);
`ifdef SATURATION_FLAG_EN
      chk("sat_out",   int'(sat_out),   mon_e.sat,  mon_e.id);
`endif
    end
  end

  initial begin
    int op;
    model_reset();
    for (int i = 0; i < NR; i++) m_light[i] = 0;
    rst_cyc(0); rst_cyc(0);

    // Row0 light 4 for 64 cycles -> code 16; row1=15, row2=0, row3=9.
    m_light[0] = 4; m_light[1] = 15; m_light[2] = 0; m_light[3] = 9;
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) cyc(0, 1, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 256; k++) cyc(0, 0, 1, 0, k);
    read_all();

    // Row1 full-scale: 255 cycles -> 239, 300 cycles -> saturated 255.
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 255; k++) cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 256; k++) cyc(0, 0, 1, 0, k);
    read_all();
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 256; k++) cyc(0, 0, 1, 0, k);
    read_all();

    // Row2 dark: latches at ramp 0, later ramp values must not re-latch.
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 100); cyc(0, 0, 1, 0, 50);
    read_all();

    // Protocol violations: sticky flag, bus not driven, memory preserved.
    cyc(0, 0, 0, 4'b0011, 0);
    idle(2);
    cyc(0, 1, 1, 0, 255);
    read_all();

    // Reset mid-conversion with rows 2 and 3 already tripped.
    m_light[0] = 15; m_light[1] = 15; m_light[2] = 0; m_light[3] = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 255; k++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 1); cyc(0, 0, 1, 0, 2);
    rst_cyc(1); rst_cyc(1);
    read_all();

`ifdef SATURATION_FLAG_EN
    m_light[0] = 1;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 0);
    read_all();
`endif

    // Random cycles with occasional resets to clear the sticky error.
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 299) rst_cyc($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < NR; i++) m_light[i] = $urandom_range(0, 15);
      op = $urandom_range(0, 99);
      if (op < 3)       cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                            $urandom_range(0, 15), $urandom_range(0, 255));
      else if (op < 8)  cyc(1, 0, 0, 0, 0);
      else if (op < 45) cyc(0, 1, 0, 0, 0);
      else if (op < 75) cyc(0, 0, 1, 0, $urandom_range(0, 255));
      else if (op < 92) cyc(0, 0, 0, 1 << $urandom_range(0, NR - 1), 0);
      else              cyc(0, 0, 0, 0, 0);
    end
    idle(1);

    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0, cyc_id);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pixel_row_memory.md
Name: pixel_row_memory

Overview:
Digital model of the pixel-array side of the shared pixel data bus: the writer that drives pixel codes onto the bus during read phases.
- Per row: integrates a light code during expose, compares against the digital ramp code during convert, latches the ramp code on trip, and drives the stored code onto the bus when that row's read strobe is high.
- Sits between the sensor FSM control strobes and the bus readout register. Used as a cycle-accurate stand-in for the analog array in digital simulation.

Parameters:
N_ROWS, 4, number of rows / read strobes
DATA_W, 8, pixel code and bus width
LIGHT_W, 4, per-row light (photocurrent) code width
ACC_W, 12, exposure accumulator width; must be >= DATA_W

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
erase  input  1  erase strobe: clear all row state
expose  input  1  exposure phase: integrate light
convert  input  1  conversion phase: ramp compare/latch
read  input  N_ROWS  one-hot row read strobes (bit i = read(i+1))
ramp_code  input  DATA_W  digital ramp value present during convert
light  input  N_ROWS*LIGHT_W  row i light code in bits [i*LIGHT_W +: LIGHT_W]
data_out  output  DATA_W  bus drive value
data_oe  output  1  bus drive enable; the bus is tri-stated by the parent when low
proto_err  output  1  sticky protocol-violation flag
busy_row  output  N_ROWS  row i has not yet latched in the current conversion

Behaviour:
- Reset (reset low, asynchronous):
  - All accumulators, row codes and tripped flags = 0.
  - State = IDLE; proto_err = 0; busy_row = 0.
  - data_out = 0; data_oe = 0.
- Phase FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ. The state is the phase sampled this cycle:
  - erase -> ERASE; expose -> EXPOSE; convert -> CONVERT; any read bit -> READ; none -> IDLE.
- Legal cycle: at most one of {erase, expose, convert, read-any} high, and read has at most one bit set.
  - On an illegal cycle: proto_err set (sticky until reset). State, accumulators and memory hold. data_oe = 0.
- ERASE: accumulators, row codes and tripped flags cleared on the edge.
- EXPOSE: each cycle acc[i] <= acc[i] + light[i], saturating at 2^ACC_W-1. No wrap.
- Threshold: thr[i] = acc[i][ACC_W-1 : ACC_W-DATA_W] (top DATA_W bits).
- Entry into CONVERT from any other state (first convert cycle): tripped flags cleared and busy_row = all ones. The compare also runs on this cycle.
- Each CONVERT cycle, for every row with tripped=0 and ramp_code >= thr[i]:
  - row code[i] <= ramp_code; tripped[i] <= 1; busy_row[i] <= 0.
  - A row latches at most once per conversion.
  - ramp_code decreasing mid-convert does not re-trigger a latch.
- Leaving CONVERT: busy_row goes to 0. Rows never tripped keep their previous row code (0 after erase); see optional feature.
- READ (legal, read bit k set):
  - data_oe = 1 and data_out = row code[k], combinational from the registered memory.
  - Zero-cycle latency, so the parent samples on the same edge.
- Outside a legal READ: data_oe = 0 and data_out = 0.
- Accumulators are not cleared by convert or read. Only erase or reset clears them.
- Reset asserted mid-operation: immediate return to reset values. No partial latch completes.

Optional Feature:
SATURATION_FLAG_EN
- Defined:
  - When leaving CONVERT, any row with tripped=0 has its row code forced to all ones (2^DATA_W-1).
  - A per-row sat bit is stored. When that row is read, sat is reported on the extra output port sat_out (1 bit, valid while data_oe=1, else 0).
  - Erase and reset clear the sat bits.
- Undefined: untripped rows keep their prior code; there is no sat_out port.

Test Plan:
- Reset, then erase 5 cycles, expose 64 cycles with light row0=4, convert with ramp 0..255, read row0 -> data_oe=1, data_out=16; busy_row[0] falls on the cycle ramp_code=16.
- light row1=15, expose 255 cycles (acc=3825, thr=239), convert, read row1 -> 239. Repeat with a 300-cycle expose -> acc saturates at 4095 -> code 255.
- light row2=0, expose, convert from ramp 0 -> latch on first convert cycle -> code 0. Ramp 100 -> 50 after latch -> code stays 0.
- Assert read=4'b0011, or expose and convert together -> proto_err=1 and stays 1. data_oe=0. Memory is unchanged on a later legal read.
- Drop reset mid-convert with 2 rows tripped -> all outputs 0 and all row codes read 0 after release.
- SATURATION_FLAG_EN: light=1, expose 16 cycles (thr=1), convert with ramp held at 0 only, read -> data_out=255, sat_out=1. Macro undefined -> data_out=0.
